// File: rtl/typer_pkg.sv
// Shared constants and types for the typing-game letter path.
package typer_pkg;

    localparam int unsigned ALPHABET_SIZE     = 26;
    localparam int unsigned RAND_ACCEPT_LIMIT = 234;
    localparam int unsigned LETTER_W          = 5;

    typedef logic [4:0] letter_t;

endpackage : typer_pkg

// File: rtl/letter_queue_if.sv
// Bus between the random source / game logic and the letter queue.
interface letter_queue_if #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LETTER_W = typer_pkg::LETTER_W
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [7:0]          random_in;
    logic                enable;
    logic                pop;
    logic [LETTER_W-1:0] letter;
    logic                valid;
    logic                full;
    logic [CNT_W-1:0]    count;

    // Game side: supplies random bytes and pops, observes the head.
    modport master (
        output random_in,
        output enable,
        output pop,
        input  letter,
        input  valid,
        input  full,
        input  count
    );

    // Queue side.
    modport slave (
        input  random_in,
        input  enable,
        input  pop,
        output letter,
        output valid,
        output full,
        output count
    );

endinterface : letter_queue_if

// File: rtl/letter_fifo.sv
// Synchronous FIFO; pops on empty are ignored, push is accepted when full only alongside a pop.
module letter_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    // Status flags and effective handshakes derived from registered state.
    always_comb begin
        w_full  = (r_count == CNT_W'(DEPTH));
        w_empty = (r_count == '0);
        w_pop   = i_pop & ~w_empty;
        w_push  = i_push & (~w_full | w_pop);
    end

    // Pointer and occupancy update; pointers wrap at DEPTH naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule : letter_fifo

// File: rtl/letter_queue.sv
// Maps random bytes to unbiased, non-repeating letters and buffers them for the game.
module letter_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LETTER_W = typer_pkg::LETTER_W
) (
    input  logic           clk,
    input  logic           reset,
    letter_queue_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [LETTER_W-1:0] r_last_letter;
    logic                r_have_last;

    logic [LETTER_W-1:0] w_cand;
    logic                w_in_range;
    logic                w_repeat;
    logic                w_pop_eff;
    logic                w_push;

    logic [LETTER_W-1:0] w_head;
    logic [CNT_W-1:0]    w_count;
    logic                w_full;
    logic                w_empty;

    // Candidate letter, rejection of the biased tail and of immediate repeats.
    always_comb begin
        w_cand     = LETTER_W'(bus.random_in % 8'(typer_pkg::ALPHABET_SIZE));
        w_in_range = (bus.random_in < 8'(typer_pkg::RAND_ACCEPT_LIMIT));
        w_repeat   = r_have_last & (w_cand == r_last_letter);
        w_pop_eff  = bus.pop & ~w_empty;
        w_push     = bus.enable & w_in_range & ~w_repeat & (~w_full | w_pop_eff);
    end

    // Remember the most recently pushed letter for the no-repeat rule.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_letter <= '0;
            r_have_last   <= 1'b0;
        end else if (w_push) begin
            r_last_letter <= w_cand;
            r_have_last   <= 1'b1;
        end
    end

    letter_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LETTER_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (bus.pop),
        .i_data  (w_cand),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.letter = w_head;
    assign bus.valid  = ~w_empty;
    assign bus.full   = w_full;
    assign bus.count  = w_count;

endmodule : letter_queue

// File: tb/tb_letter_queue.sv
// Directed self-checking bench for letter_queue.
module tb_letter_queue;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_err;

    letter_queue_if #(.DEPTH(8), .LETTER_W(5)) bus ();

    letter_queue #(
        .DEPTH    (8),
        .LETTER_W (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int cnt, input int vld,
                             input int lt, input int ful);
        chk({tag, ".count"},  32'(bus.count),  32'(cnt));
        chk({tag, ".valid"},  32'(bus.valid),  32'(vld));
        chk({tag, ".letter"}, 32'(bus.letter), 32'(lt));
        chk({tag, ".full"},   32'(bus.full),   32'(ful));
    endtask

    initial begin
        n_checks      = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.pop       = 1'b0;
        bus.random_in = 8'd0;
        step();
        step();
        chk_state("reset", 0, 0, 0, 0);

        // 0x00 -> letter 0, then 0xEA (234) is rejected
        reset         = 1'b0;
        bus.enable    = 1'b1;
        bus.random_in = 8'h00;
        step();
        chk_state("push0", 1, 1, 0, 0);
        bus.random_in = 8'hEA;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("rej234", 1, 1, 0, 0);
        end
        bus.enable = 1'b0;
        bus.pop    = 1'b1;
        step();
        chk_state("drain1", 0, 0, 0, 0);
        bus.pop = 1'b0;

        // 27,26,52 -> letters 1,0 then repeat 0 rejected
        bus.enable    = 1'b1;
        bus.random_in = 8'd27;
        step();
        chk_state("seq27", 1, 1, 1, 0);
        bus.random_in = 8'd26;
        step();
        chk_state("seq26", 2, 1, 1, 0);
        bus.random_in = 8'd52;
        step();
        chk_state("seq52rep", 2, 1, 1, 0);
        bus.enable = 1'b0;
        bus.pop    = 1'b1;
        step();
        chk_state("seqpop1", 1, 1, 0, 0);
        step();
        chk_state("seqpop2", 0, 0, 0, 0);
        bus.pop = 1'b0;

        // Reset clears the repeat tracker, then fill with 0..7
        reset = 1'b1;
        step();
        reset      = 1'b0;
        bus.enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.random_in = 8'(i);
            step();
            chk("fill.count", 32'(bus.count), 32'(i + 1));
        end
        chk_state("full8", 8, 1, 0, 1);
        bus.random_in = 8'd8;
        step();
        chk_state("fullrej", 8, 1, 0, 1);
        bus.pop = 1'b1;
        step();
        chk_state("fullpushpop", 8, 1, 1, 1);
        bus.enable = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("drain.head", 32'(bus.letter), 32'(k));
            chk("drain.count", 32'(bus.count), 32'(9 - k));
            step();
        end
        chk_state("drained", 0, 0, 0, 0);

        // Pops on an empty queue are ignored
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("emptypop", 0, 0, 0, 0);
        end
        bus.pop       = 1'b0;
        bus.enable    = 1'b1;
        bus.random_in = 8'd3;
        step();
        chk_state("afterempty", 1, 1, 3, 0);

        // Push and pop together at count 1: head replaced
        bus.pop       = 1'b1;
        bus.random_in = 8'd27;
        step();
        chk_state("pp1", 1, 1, 1, 0);
        bus.pop       = 1'b0;
        bus.random_in = 8'd233;
        step();
        chk_state("lim233", 2, 1, 1, 0);
        bus.random_in = 8'd255;
        step();
        chk_state("rej255", 2, 1, 1, 0);

        // Enable low blocks pushes, pops still drain
        bus.enable    = 1'b0;
        bus.random_in = 8'd10;
        step();
        chk_state("disabled", 2, 1, 1, 0);
        bus.pop = 1'b1;
        step();
        chk_state("dispop", 1, 1, 25, 0);
        bus.pop    = 1'b0;
        bus.enable = 1'b1;
        bus.random_in = 8'd10;
        step();
        bus.random_in = 8'd11;
        step();
        bus.random_in = 8'd4;
        step();
        bus.random_in = 8'd3;
        step();
        chk_state("five", 5, 1, 25, 0);

        // Reset wins over pop and push, and forgets the last letter
        reset         = 1'b1;
        bus.pop       = 1'b1;
        bus.random_in = 8'd3;
        step();
        chk_state("rstmid", 0, 0, 0, 0);
        reset   = 1'b0;
        bus.pop = 1'b0;
        step();
        chk_state("postrst", 1, 1, 3, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_letter_queue
